// File: rtl/gsim_sched.sv
// -----------------------------------------------------------------------------
// gsim_sched
// Sequencer for the rotating operand shift register of the Gauss-Seidel solver
// datapath. A solve has four phases:
//   LOAD  : accept N_ELEM operands through in_valid/in_ready, shifting each in
//   ISSUE/WAIT : for every element start the PE, wait for its result and write
//           it back by shift-and-load; repeat for the latched iteration count
//   OUT   : stream the final vector through out_valid/out_ready
//   FIN   : one-cycle done pulse
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, iter_num       begin a solve (IDLE only) / iteration count
//   in_valid, in_ready    operand load handshake
//   pe_start, x_idx       PE kick pulse and element index being computed
//   pe_done               PE result valid (result sits on shift-register input)
//   sh_ctrl, sh_ld        shift-register mode (00 SH1, 11 HOLD) and load enable
//   out_valid, out_idx    final vector element valid and its index
//   out_ready             downstream accept
//   busy, done            solve in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module gsim_sched #(
    parameter int N_ELEM = 16,
    parameter int IDX_W  = 4,
    parameter int ITER_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] iter_num,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pe_start,
    output logic [IDX_W-1:0]  x_idx,
    input  logic              pe_done,
    output logic [1:0]        sh_ctrl,
    output logic              sh_ld,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    // SH4 (2'b01) and SH5 (2'b10) are reserved and never driven here.
    localparam logic [1:0] SH_1    = 2'b00;
    localparam logic [1:0] SH_HOLD = 2'b11;

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_ELEM - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ITER_W-1:0] ITER_MAX = {ITER_W{1'b1}};
    localparam logic [ITER_W-1:0] ITER_ONE = ITER_W'(1);
    localparam logic [ITER_W:0]   ITER_ONE_X = (ITER_W + 1)'(1);

    logic [2:0]        state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [ITER_W-1:0] iter_cnt_r;
    logic [ITER_W-1:0] iter_lat_r;
    logic              iter_more_s;
    logic [ITER_W-1:0] iter_cnt_inc_s;

    // Another sweep is due when the finished iteration count is still below
    // the latched target; widened by one bit so the +1 cannot wrap.
    assign iter_more_s    = ({1'b0, iter_cnt_r} + ITER_ONE_X) < {1'b0, iter_lat_r};
    assign iter_cnt_inc_s = (iter_cnt_r == ITER_MAX) ? iter_cnt_r : (iter_cnt_r + ITER_ONE);

    // Sequencer state, element index and iteration bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            iter_cnt_r <= {ITER_W{1'b0}};
            iter_lat_r <= {ITER_W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        // A zero count is treated as a single sweep.
                        iter_lat_r <= (iter_num == {ITER_W{1'b0}}) ? ITER_ONE : iter_num;
                        idx_r      <= {IDX_W{1'b0}};
                        iter_cnt_r <= {ITER_W{1'b0}};
                        state_r    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (idx_r == IDX_LAST) begin
                            idx_r      <= {IDX_W{1'b0}};
                            iter_cnt_r <= {ITER_W{1'b0}};
                            state_r    <= S_ISSUE;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (pe_done) begin
                        if (idx_r != IDX_LAST) begin
                            idx_r   <= idx_r + IDX_ONE;
                            state_r <= S_ISSUE;
                        end else if (iter_more_s) begin
                            idx_r      <= {IDX_W{1'b0}};
                            iter_cnt_r <= iter_cnt_inc_s;
                            state_r    <= S_ISSUE;
                        end else begin
                            idx_r   <= {IDX_W{1'b0}};
                            state_r <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (idx_r == IDX_LAST) begin
                            idx_r   <= {IDX_W{1'b0}};
                            state_r <= S_FIN;
                        end else begin
                            idx_r <= idx_r + IDX_ONE;
                        end
                    end
                end
                S_FIN: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from state, index and the same-cycle handshake inputs.
    always_comb begin
        in_ready  = 1'b0;
        pe_start  = 1'b0;
        sh_ctrl   = SH_HOLD;
        sh_ld     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        x_idx     = idx_r;
        out_idx   = idx_r;
        case (state_r)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    sh_ctrl = SH_1;
                    sh_ld   = 1'b1;
                end else begin
                    sh_ctrl = SH_HOLD;
                end
            end
            S_ISSUE: begin
                busy     = 1'b1;
                pe_start = 1'b1;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (pe_done) begin
                    sh_ctrl = SH_1;
                    sh_ld   = 1'b1;
                end else begin
                    sh_ctrl = SH_HOLD;
                end
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Rotate without loading so the vector returns to its order.
                if (out_ready) begin
                    sh_ctrl = SH_1;
                end else begin
                    sh_ctrl = SH_HOLD;
                end
            end
            S_FIN: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
